mp_adder_ctrl: RTL and testbench

//  Sequences a full-precision OP_WIDTH add or subtract through one SEG_WIDTH bk_adder

---
 rtl/rsa_pkg.sv | 16 +
 rtl/mp_adder_ctrl_if.sv | 26 ++
 rtl/bk_adder.sv | 15 +
 rtl/mp_adder_ctrl.sv | 103 ++++++++++
 tb/tb_mp_adder_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared constants for the modexp datapath: segment width, add/sub mode codes
// and the state encoding of the segment-serial adder controller.
package rsa_pkg;

  localparam int SEG_WIDTH_DFLT = 64;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mp_adder_ctrl_if.sv
// start/busy/done handshake plus operand and result buses of the
// multi-precision adder controller.
interface mp_adder_ctrl_if #(
  parameter int OP_WIDTH = 1024
);

  logic                start;
  logic                mode;
  logic [OP_WIDTH-1:0] op_a;
  logic [OP_WIDTH-1:0] op_b;
  logic                busy;
  logic                done;
  logic [OP_WIDTH-1:0] result;
  logic                carry_out;

  modport master (
    output start, mode, op_a, op_b,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, mode, op_a, op_b,
    output busy, done, result, carry_out
  );

endinterface

// File: rtl/bk_adder.sv
// One segment of the long adder: WIDTH-bit sum with carry in and carry out.
module bk_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Written behaviourally so synthesis maps it onto the dedicated carry chain.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mp_adder_ctrl.sv
// Full-width add/subtract sequenced LSB-first through one SEG_WIDTH adder,
// one segment per clock, with the inter-segment carry held in a flop.
module mp_adder_ctrl
  import rsa_pkg::*;
#(
  parameter int OP_WIDTH  = 1024,
  parameter int SEG_WIDTH = SEG_WIDTH_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  mp_adder_ctrl_if.slave     bus
);

  localparam int NUM_SEG = OP_WIDTH / SEG_WIDTH;
  localparam int CNT_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEG - 1);

  generate
    if (OP_WIDTH % SEG_WIDTH != 0) begin : g_width_chk
      $error("mp_adder_ctrl: OP_WIDTH must be a multiple of SEG_WIDTH");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [OP_WIDTH-1:0] a_sh_reg, b_sh_reg, acc_reg, result_reg;
  logic                cy_reg, carry_reg;
  logic [CNT_W-1:0]    seg_cnt_reg;

  logic [SEG_WIDTH-1:0] seg_sum;
  logic                 seg_cy;
  logic [OP_WIDTH-1:0]  acc_shift;

  bk_adder #(.WIDTH(SEG_WIDTH)) u_seg_add (
    .a    (a_sh_reg[SEG_WIDTH-1:0]),
    .b    (b_sh_reg[SEG_WIDTH-1:0]),
    .cin  (cy_reg),
    .sum  (seg_sum),
    .cout (seg_cy)
  );

  // New sum segment enters at the MSB end; after NUM_SEG steps acc is LSB-aligned.
  assign acc_shift = OP_WIDTH'({seg_sum, acc_reg} >> SEG_WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (seg_cnt_reg == LAST_SEG) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg    <= '0;
      b_sh_reg    <= '0;
      acc_reg     <= '0;
      cy_reg      <= 1'b0;
      seg_cnt_reg <= '0;
      result_reg  <= '0;
      carry_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            a_sh_reg    <= bus.op_a;
            b_sh_reg    <= (bus.mode == MODE_SUB) ? ~bus.op_b : bus.op_b;
            cy_reg      <= (bus.mode == MODE_SUB);
            seg_cnt_reg <= '0;
          end
        end
        ST_RUN: begin
          a_sh_reg    <= a_sh_reg >> SEG_WIDTH;
          b_sh_reg    <= b_sh_reg >> SEG_WIDTH;
          acc_reg     <= acc_shift;
          cy_reg      <= seg_cy;
          seg_cnt_reg <= seg_cnt_reg + 1'b1;
          if (seg_cnt_reg == LAST_SEG) begin
            result_reg <= acc_shift;
            carry_reg  <= seg_cy;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = (state_reg == ST_DONE);
  assign bus.result    = result_reg;
  assign bus.carry_out = carry_reg;

endmodule

// File: tb/tb_mp_adder_ctrl.sv
// Directed and random checks of mp_adder_ctrl at 4 segments (256/64) and 1 segment (64/64).
module tb_mp_adder_ctrl;

  localparam int BW = 256;
  localparam int SW = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mp_adder_ctrl_if #(.OP_WIDTH(BW)) bus ();
  mp_adder_ctrl_if #(.OP_WIDTH(SW)) bus1 ();

  mp_adder_ctrl #(.OP_WIDTH(BW), .SEG_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mp_adder_ctrl #(.OP_WIDTH(SW), .SEG_WIDTH(SW)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op on the 256-bit DUT; returns at the negedge inside the done
  // cycle. edges counts the accept edge plus every edge up to done.
  task automatic op_big(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic m,
                        output int edges, output int busy_cyc);
    @(negedge clk);
    bus.op_a = a; bus.op_b = b; bus.mode = m; bus.start = 1'b1;
    @(posedge clk);
    edges = 1; busy_cyc = 0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && edges < 20) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk); edges++;
      @(negedge clk);
    end
    if (bus.busy) busy_cyc++;
  endtask

  task automatic op_small(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic m,
                          output int edges);
    @(negedge clk);
    bus1.op_a = a; bus1.op_b = b; bus1.mode = m; bus1.start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus1.start = 1'b0;
    while (!bus1.done && edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [BW-1:0] a, b, exp_r;
    logic [SW-1:0] sa, sb, sexp_r;
    logic          m, exp_c, seen;
    int            edges, busy_cyc;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus1.start = 1'b0; bus1.mode = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 257'(bus.busy), 257'(0));
    check("rst_done", 257'(bus.done), 257'(0));
    check("rst_result", 257'(bus.result), 257'(0));
    check("rst_carry", 257'(bus.carry_out), 257'(0));
    rst_n = 1'b1;

    // 1: carry crosses from segment 0 into segment 1
    a = '0; a[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_r = '0; exp_r[64] = 1'b1;
    op_big(a, 256'd1, 1'b0, edges, busy_cyc);
    check("t1_done", 257'(bus.done), 257'(1));
    check("t1_edges", 257'(edges), 257'(5));
    check("t1_busy_cycles", 257'(busy_cyc), 257'(5));
    check("t1_result", 257'(bus.result), 257'(exp_r));
    check("t1_carry", 257'(bus.carry_out), 257'(0));

    // 2: full-width overflow
    a = '1;
    op_big(a, 256'd1, 1'b0, edges, busy_cyc);
    check("t2_result", 257'(bus.result), 257'(0));
    check("t2_carry", 257'(bus.carry_out), 257'(1));

    // 3: subtract without and with borrow
    op_big(256'd7, 256'd5, 1'b1, edges, busy_cyc);
    check("t3a_result", 257'(bus.result), 257'(2));
    check("t3a_carry", 257'(bus.carry_out), 257'(1));
    op_big(256'd5, 256'd7, 1'b1, edges, busy_cyc);
    exp_r = '1; exp_r[0] = 1'b0;
    check("t3b_result", 257'(bus.result), 257'(exp_r));
    check("t3b_carry", 257'(bus.carry_out), 257'(0));

    // 4: start and operand changes while busy are ignored
    @(negedge clk);
    bus.op_a = 256'd100; bus.op_b = 256'd23; bus.mode = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op_a = '1; bus.op_b = '1; bus.mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 256'd5; bus.op_b = 256'd5;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10 && !bus.done; i++) @(negedge clk);
    check("t4_done", 257'(bus.done), 257'(1));
    check("t4_result", 257'(bus.result), 257'(123));
    check("t4_carry", 257'(bus.carry_out), 257'(0));
    bus.start = 1'b1; bus.op_a = 256'd9; bus.op_b = 256'd9; bus.mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("t4_done_one_cycle", 257'(bus.done), 257'(0));
    check("t4_no_accept_busy", 257'(bus.busy), 257'(0));
    @(negedge clk);
    check("t4_still_idle", 257'(bus.busy), 257'(0));
    check("t4_result_held", 257'(bus.result), 257'(123));

    // 5: reset mid-run aborts and clears outputs
    @(negedge clk);
    bus.op_a = 256'd1; bus.op_b = 256'd1; bus.mode = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 257'(bus.busy), 257'(0));
    check("t5_done", 257'(bus.done), 257'(0));
    check("t5_result", 257'(bus.result), 257'(0));
    check("t5_carry", 257'(bus.carry_out), 257'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | bus.done;
    end
    check("t5_no_done", 257'(seen), 257'(0));
    op_big(256'd3, 256'd4, 1'b0, edges, busy_cyc);
    check("t5_after_result", 257'(bus.result), 257'(7));
    check("t5_after_carry", 257'(bus.carry_out), 257'(0));

    // 6a: back-to-back random ops, 4 segments
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 8; k++) begin
        a[k*32 +: 32] = $urandom();
        b[k*32 +: 32] = $urandom();
      end
      m = 1'($urandom_range(0, 1));
      if (m) begin
        exp_r = a - b;
        exp_c = (a >= b);
      end else begin
        {exp_c, exp_r} = {1'b0, a} + {1'b0, b};
      end
      op_big(a, b, m, edges, busy_cyc);
      check("r4_edges", 257'(edges), 257'(5));
      check("r4_result", 257'(bus.result), 257'(exp_r));
      check("r4_carry", 257'(bus.carry_out), 257'(exp_c));
    end

    // 6b: single-segment instance
    op_small(64'd5, 64'd7, 1'b1, edges);
    check("s1_edges", 257'(edges), 257'(2));
    check("s1_result", 257'(bus1.result), 257'(64'hFFFF_FFFF_FFFF_FFFE));
    check("s1_carry", 257'(bus1.carry_out), 257'(0));
    for (int n = 0; n < 1000; n++) begin
      sa = {$urandom(), $urandom()};
      sb = {$urandom(), $urandom()};
      m = 1'($urandom_range(0, 1));
      if (m) begin
        sexp_r = sa - sb;
        exp_c = (sa >= sb);
      end else begin
        {exp_c, sexp_r} = {1'b0, sa} + {1'b0, sb};
      end
      op_small(sa, sb, m, edges);
      check("r1_edges", 257'(edges), 257'(2));
      check("r1_result", 257'(bus1.result), 257'(sexp_r));
      check("r1_carry", 257'(bus1.carry_out), 257'(exp_c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
